// File: rtl/control_sequencer.sv
// Hardwired micro-sequencer: fetch (T0-T2), decode (T3) and execute (T4-T6) strobes for the datapath.
// Optional MUL/DIV support (Z high half, HI/LO writeback, T6) is enabled by defining CTRL_MULDIV_EN.
module control_sequencer (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic        stop,
    input  logic        mem_wait,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  opcode,
    output logic        Run
);

    localparam int unsigned OP_W  = 5;
    localparam int unsigned REG_W = 4;
    localparam int unsigned SEL_W = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_HALT
`ifdef CTRL_MULDIV_EN
        , S_T6
`endif
    } state_e;

    state_e state_q, state_d;

    logic [OP_W-1:0]  ir_op;
    logic [REG_W-1:0] ra, rb, rc;
    logic             is_alu, is_muldiv, is_halt;
    logic             unused_ir;

    assign ir_op     = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

    assign is_alu  = (ir_op >= OP_W'(3)) && (ir_op <= OP_W'(12));
    assign is_halt = (ir_op == OP_W'(27));
`ifdef CTRL_MULDIV_EN
    assign is_muldiv = (ir_op == OP_W'(15)) || (ir_op == OP_W'(16));
`else
    assign is_muldiv = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore strobe decode from the current state and IR.
    always_comb begin
        state_d  = state_q;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        Read     = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowIn   = 1'b0;
        ZHighIn  = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        opcode   = '0;
        Run      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_T0;
            end
            S_T0: begin
                Run     = 1'b1;
                PCout   = 1'b1;
                MARin   = 1'b1;
                IncPC   = 1'b1;
                state_d = stop ? S_HALT : S_T1;
            end
            S_T1: begin
                Run   = 1'b1;
                Read  = 1'b1;
                MDRin = 1'b1;
                if (!mem_wait) state_d = S_T2;
            end
            S_T2: begin
                Run     = 1'b1;
                MDRout  = 1'b1;
                IRin    = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                Run = 1'b1;
                if (is_alu || is_muldiv) begin
                    Rout    = SEL_W'(1) << rb;
                    Yin     = 1'b1;
                    state_d = S_T4;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_T0;
                end
            end
            S_T4: begin
                Run     = 1'b1;
                Rout    = SEL_W'(1) << rc;
                opcode  = ir_op;
                ZLowIn  = 1'b1;
`ifdef CTRL_MULDIV_EN
                ZHighIn = is_muldiv;
`endif
                state_d = S_T5;
            end
            S_T5: begin
                Run     = 1'b1;
                Zlowout = 1'b1;
`ifdef CTRL_MULDIV_EN
                if (is_muldiv) begin
                    LOin    = 1'b1;
                    state_d = S_T6;
                end else begin
                    Rin     = SEL_W'(1) << ra;
                    state_d = S_T0;
                end
`else
                Rin     = SEL_W'(1) << ra;
                state_d = S_T0;
`endif
            end
`ifdef CTRL_MULDIV_EN
            S_T6: begin
                Run      = 1'b1;
                Zhighout = 1'b1;
                HIin     = 1'b1;
                state_d  = S_T0;
            end
`endif
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed vector table, a stop-in-T3 sequence and random
// stimulus checked against a queue-of-micro-steps reference model.
module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        mem_wait = 1'b0;
    logic [31:0] IR = 32'h0;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin;
    logic        ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin, Run;
    logic [15:0] Rin, Rout;
    logic [4:0]  opcode;

    int total = 0;
    int bad   = 0;

`ifdef CTRL_MULDIV_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    localparam logic [31:0] SUB = 32'h221B8000;
    localparam logic [31:0] HLT = 32'hD8000000;
    localparam logic [31:0] MUL = 32'h78980000;

    typedef struct packed {
        logic        pcout, pcin, incpc, marin, mdrin, mdrout, read, irin, yin;
        logic        zlowin, zhighin, zlowout, zhighout, hiin, loin;
        logic [15:0] rin, rout;
        logic [4:0]  opcode;
        logic        run;
    } outs_t;

    typedef struct {
        logic        clr, st, sp, mw;
        logic [31:0] ir;
        outs_t       exp;
        string       name;
    } vec_t;

    outs_t act;
    assign act = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin,
                  ZLowIn, ZHighIn, Zlowout, Zhighout, HIin, LOin, Rin, Rout, opcode, Run};

    control_sequencer dut (
        .clock(clock), .clear(clear), .start(start), .stop(stop), .mem_wait(mem_wait), .IR(IR),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
        .Read(Read), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
        .Rin(Rin), .Rout(Rout), .opcode(opcode), .Run(Run)
    );

    always #5 clock = ~clock;

    // Expected output patterns per micro-step.
    function automatic outs_t o_zero();
        outs_t o;
        o = '0;
        return o;
    endfunction
    function automatic outs_t o_busy();
        outs_t o;
        o = '0; o.run = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_t0();
        outs_t o;
        o = o_busy(); o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_t1();
        outs_t o;
        o = o_busy(); o.read = 1'b1; o.mdrin = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_t2();
        outs_t o;
        o = o_busy(); o.mdrout = 1'b1; o.irin = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_t3(input logic [15:0] rout);
        outs_t o;
        o = o_busy(); o.rout = rout; o.yin = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_t4(input logic [15:0] rout, input logic [4:0] op, input logic hi);
        outs_t o;
        o = o_busy(); o.rout = rout; o.opcode = op; o.zlowin = 1'b1; o.zhighin = hi;
        return o;
    endfunction
    function automatic outs_t o_t5a(input logic [15:0] rin);
        outs_t o;
        o = o_busy(); o.zlowout = 1'b1; o.rin = rin;
        return o;
    endfunction
    function automatic outs_t o_t5m();
        outs_t o;
        o = o_busy(); o.zlowout = 1'b1; o.loin = 1'b1;
        return o;
    endfunction
    function automatic outs_t o_t6();
        outs_t o;
        o = o_busy(); o.zhighout = 1'b1; o.hiin = 1'b1;
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic s, input logic p, input logic m,
                         input logic [31:0] ir);
        clear = c; start = s; stop = p; mem_wait = m; IR = ir;
    endtask

    // Reference model: pending micro-steps of the current instruction, each with a tag.
    localparam int TG_PLAIN = 0, TG_FETCH = 1, TG_MEM = 2, TG_LOAD = 3, TG_HDEC = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
    int    mode = M_IDLE;
    outs_t mq[$];
    int    tq[$];

    task automatic push(input outs_t o, input int t);
        mq.push_back(o);
        tq.push_back(t);
    endtask

    task automatic refill_fetch();
        mq.delete(); tq.delete();
        push(o_t0(), TG_FETCH);
        push(o_t1(), TG_MEM);
        push(o_t2(), TG_LOAD);
    endtask

    task automatic push_exec(input logic [31:0] ir);
        int unsigned op, ra, rb, rc;
        op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
        if (op >= 3 && op <= 12) begin
            push(o_t3(16'd1 << rb), TG_PLAIN);
            push(o_t4(16'd1 << rc, 5'(op), 1'b0), TG_PLAIN);
            push(o_t5a(16'd1 << ra), TG_PLAIN);
        end else if (MD_EN && (op == 15 || op == 16)) begin
            push(o_t3(16'd1 << rb), TG_PLAIN);
            push(o_t4(16'd1 << rc, 5'(op), 1'b1), TG_PLAIN);
            push(o_t5m(), TG_PLAIN);
            push(o_t6(), TG_PLAIN);
        end else if (op == 27) begin
            push(o_busy(), TG_HDEC);
        end else begin
            push(o_busy(), TG_PLAIN);
        end
    endtask

    task automatic model_step(input logic c, input logic s, input logic p, input logic m,
                              input logic [31:0] ir);
        int t;
        if (c) begin
            mode = M_IDLE; mq.delete(); tq.delete();
        end else if (mode == M_IDLE) begin
            if (s) begin
                mode = M_RUN; refill_fetch();
            end
        end else if (mode == M_RUN) begin
            t = tq[0];
            if (t == TG_FETCH && p) begin
                mode = M_HALT; mq.delete(); tq.delete();
            end else if (t == TG_HDEC) begin
                mode = M_HALT; mq.delete(); tq.delete();
            end else if (!(t == TG_MEM && m)) begin
                void'(mq.pop_front()); void'(tq.pop_front());
                if (t == TG_LOAD) push_exec(ir);
            end
            if (mode == M_RUN && mq.size() == 0) refill_fetch();
        end
    endtask

    function automatic outs_t model_out();
        if (mode == M_RUN) return mq[0];
        return o_zero();
    endfunction

    function automatic logic [31:0] rand_ir();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 0) r[31:27] = 5'($urandom_range(3, 12));
        else if ($urandom_range(0, 3) == 0) r[31:27] = ($urandom_range(0, 1) == 0) ? 5'd15 : 5'd16;
        return r;
    endfunction

    vec_t vecs[$];

    function automatic void addv(input logic c, input logic s, input logic p, input logic m,
                                 input logic [31:0] ir, input outs_t e, input string n);
        vec_t v;
        v.clr = c; v.st = s; v.sp = p; v.mw = m; v.ir = ir; v.exp = e; v.name = n;
        vecs.push_back(v);
    endfunction

    initial begin
        logic        rc, rs, rp, rm;
        logic [31:0] rir;

        // Inputs applied before each edge, outputs expected after it.
        addv(1, 0, 0, 0, SUB, o_zero(), "reset");
        addv(0, 1, 0, 0, SUB, o_t0(), "sub_t0");
        addv(0, 0, 0, 0, SUB, o_t1(), "sub_t1");
        addv(0, 0, 0, 0, SUB, o_t2(), "sub_t2");
        addv(0, 0, 0, 0, SUB, o_t3(16'h0008), "sub_t3");
        addv(0, 0, 0, 0, SUB, o_t4(16'h0080, 5'b00100, 1'b0), "sub_t4");
        addv(0, 0, 0, 0, SUB, o_t5a(16'h0010), "sub_t5");
        addv(0, 0, 0, 0, SUB, o_t0(), "sub_next_t0");
        addv(0, 0, 0, 0, SUB, o_t1(), "wait_t1_a");
        addv(0, 0, 0, 1, SUB, o_t1(), "wait_t1_b");
        addv(0, 0, 0, 1, SUB, o_t1(), "wait_t1_c");
        addv(0, 0, 0, 1, SUB, o_t1(), "wait_t1_d");
        addv(0, 0, 0, 0, SUB, o_t2(), "wait_t2");
        addv(0, 0, 0, 0, SUB, o_t3(16'h0008), "wait_t3");
        addv(0, 0, 0, 0, SUB, o_t4(16'h0080, 5'b00100, 1'b0), "wait_t4");
        addv(1, 1, 0, 0, SUB, o_zero(), "clear_in_t4");
        addv(0, 0, 0, 0, SUB, o_zero(), "idle_hold");
        addv(0, 1, 1, 0, SUB, o_t0(), "start_wins");
        addv(0, 0, 1, 0, SUB, o_zero(), "stop_t0_halt");
        addv(0, 1, 0, 0, SUB, o_zero(), "halt_ignores_start");
        addv(1, 0, 0, 0, SUB, o_zero(), "halt_clear");
        addv(0, 1, 0, 0, HLT, o_t0(), "hlt_t0");
        addv(0, 0, 0, 0, HLT, o_t1(), "hlt_t1");
        addv(0, 0, 0, 0, HLT, o_t2(), "hlt_t2");
        addv(0, 0, 0, 0, HLT, o_busy(), "hlt_t3");
        addv(0, 0, 0, 0, HLT, o_zero(), "hlt_halted");
        addv(0, 1, 0, 0, HLT, o_zero(), "hlt_start_ignored");
        addv(1, 0, 0, 0, HLT, o_zero(), "hlt_clear");
        addv(0, 1, 0, 0, MUL, o_t0(), "mul_t0");
        addv(0, 0, 0, 0, MUL, o_t1(), "mul_t1");
        addv(0, 0, 0, 0, MUL, o_t2(), "mul_t2");
`ifdef CTRL_MULDIV_EN
        addv(0, 0, 0, 0, MUL, o_t3(16'h0008), "mul_t3");
        addv(0, 0, 0, 0, MUL, o_t4(16'h0001, 5'b01111, 1'b1), "mul_t4");
        addv(0, 0, 0, 0, MUL, o_t5m(), "mul_t5");
        addv(0, 0, 0, 0, MUL, o_t6(), "mul_t6");
        addv(0, 0, 0, 0, MUL, o_t0(), "mul_next_t0");
`else
        addv(0, 0, 0, 0, MUL, o_busy(), "mul_nop_t3");
        addv(0, 0, 0, 0, MUL, o_t0(), "mul_nop_t0");
        addv(0, 0, 0, 0, MUL, o_t1(), "mul_nop_t1");
        addv(0, 0, 0, 0, MUL, o_t2(), "mul_nop_t2");
        addv(0, 0, 0, 0, MUL, o_busy(), "mul_nop_t3b");
`endif
        addv(1, 0, 0, 0, MUL, o_zero(), "mul_clear");

        foreach (vecs[i]) begin
            drive(vecs[i].clr, vecs[i].st, vecs[i].sp, vecs[i].mw, vecs[i].ir);
            @(posedge clock); #1;
            check(vecs[i].name, vecs[i].exp);
        end

        // stop raised in T3 lets the instruction finish, then halts at the next T0.
        drive(0, 1, 0, 0, SUB); @(posedge clock); #1; check("st3_t0", o_t0());
        drive(0, 0, 0, 0, SUB); @(posedge clock); #1; check("st3_t1", o_t1());
        @(posedge clock); #1; check("st3_t2", o_t2());
        @(posedge clock); #1; check("st3_t3", o_t3(16'h0008));
        drive(0, 0, 1, 0, SUB);
        @(posedge clock); #1; check("st3_t4", o_t4(16'h0080, 5'b00100, 1'b0));
        @(posedge clock); #1; check("st3_t5", o_t5a(16'h0010));
        @(posedge clock); #1; check("st3_t0_again", o_t0());
        @(posedge clock); #1; check("st3_halt", o_zero());
        drive(1, 0, 0, 0, SUB); @(posedge clock); #1; check("st3_clear", o_zero());

        // Random stimulus against the reference model.
        mode = M_IDLE; mq.delete(); tq.delete();
        rir = rand_ir();
        for (int n = 0; n < 4000; n++) begin
            rc = ($urandom_range(0, 49) == 0) || (mode == M_HALT && $urandom_range(0, 5) == 0);
            rs = 1'($urandom_range(0, 1));
            rp = ($urandom_range(0, 9) == 0);
            rm = ($urandom_range(0, 2) == 0);
            if (mode != M_RUN || tq[0] == TG_FETCH) rir = rand_ir();
            drive(rc, rs, rp, rm, rir);
            @(posedge clock);
            model_step(rc, rs, rp, rm, rir);
            #1;
            check("random", model_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
